id_hazard_scoreboard: RTL and testbench

//   Issue scheduler for the instruction-decode stage of the pipelined core.

---
 rtl/id_hazard_scoreboard.sv | 155 +++++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard
//
// Issue scheduler for the instruction-decode stage. It tracks register-file
// writes that have issued from ID but have not yet reached WB. Each
// architectural register 1..31 has a small counter of outstanding writes.
// ID is stalled when:
//   - a source register still has a write outstanding (RAW hazard), or
//   - the destination's counter is already at MAX_INFLIGHT.
// Register 0 is hard-wired. It is never pending and never counted.
//
// Optional feature (compile-time macro WB_BYPASS_EN):
//   When WB_BYPASS_EN is defined, the register file is write-through. A
//   source whose last outstanding write is retiring in WB this very cycle is
//   not a hazard, so the consumer issues in the WB cycle.
//   When WB_BYPASS_EN is undefined, the hazard holds through the WB cycle.
//
// Parameters:
//   MAX_INFLIGHT  max outstanding writes per register
//   PERF_W        width of the saturating stall-cycle counter
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous reset, active low (0 = reset)
//   id_valid       valid instruction present in ID
//   id_rs, id_rt   source registers
//   id_uses_rs/rt  instruction actually reads rs / rt
//   id_writes      instruction writes a register
//   id_dst         destination register
//   id_kill        squash the ID instruction this cycle
//   wb_valid       register-file write this cycle
//   wb_reg         register written at WB
//   stall          hold PC and IF/ID this cycle
//   issue          ID instruction advances to EX this cycle
//   hazard_rs/rt   source blocked by an outstanding write
//   pending_cnt    total outstanding writes across all registers
//   stall_cycles   saturating count of stalled cycles
//   err_underflow  sticky: WB seen for a register with nothing pending
// ---------------------------------------------------------------------------
module id_hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_writes,
  input  logic [4:0]        id_dst,
  input  logic              id_kill,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  output logic              stall,
  output logic              issue,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic [6:0]        pending_cnt,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              err_underflow
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Entry 0 exists only so that every 5-bit index is in range. It is reset
  // and never incremented, so it always reads as zero.
  logic [CW-1:0] cnt_q [32];

  logic [CW-1:0] cnt_rs, cnt_rt, cnt_dst, cnt_wb;
  logic          full_dst;
  logic          counted_issue, counted_wb, wb_underflow;
  logic [31:0]   inc_vec, dec_vec;
  logic          bypass_rs, bypass_rt;

  assign cnt_rs  = cnt_q[id_rs];
  assign cnt_rt  = cnt_q[id_rt];
  assign cnt_dst = cnt_q[id_dst];
  assign cnt_wb  = cnt_q[wb_reg];

`ifdef WB_BYPASS_EN
  // The last outstanding write retires in WB this cycle. The write-through
  // register file hands the new value straight to ID.
  assign bypass_rs = wb_valid && (wb_reg == id_rs) && (cnt_rs == CNT_ONE);
  assign bypass_rt = wb_valid && (wb_reg == id_rt) && (cnt_rt == CNT_ONE);
`else
  assign bypass_rs = 1'b0;
  assign bypass_rt = 1'b0;
`endif

  assign hazard_rs = id_valid && id_uses_rs && (id_rs != 5'd0) &&
                     (cnt_rs != '0) && !bypass_rs;
  assign hazard_rt = id_valid && id_uses_rt && (id_rt != 5'd0) &&
                     (cnt_rt != '0) && !bypass_rt;
  assign full_dst  = id_valid && id_writes && (id_dst != 5'd0) &&
                     (cnt_dst == CNT_FULL);

  // A killed instruction is squashed. Stalling it would be pointless.
  assign stall = (hazard_rs || hazard_rt || full_dst) && !id_kill;
  assign issue = id_valid && !stall && !id_kill;

  assign counted_issue = issue && id_writes && (id_dst != 5'd0);
  assign counted_wb    = wb_valid && (wb_reg != 5'd0) && (cnt_wb != '0);
  assign wb_underflow  = wb_valid && (wb_reg != 5'd0) && (cnt_wb == '0);

  // One-hot increment/decrement requests per register.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    inc_vec = '0;
    dec_vec = '0;
    if (counted_issue) inc_vec[id_dst] = 1'b1;
    if (counted_wb)    dec_vec[wb_reg] = 1'b1;
  end

  // NOTE: this counter array is explicitly reset. Unlike a data RAM, its
  // contents are control state, and a reset must discard every pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      // The same register increments and decrements on one edge: net unchanged.
      for (int i = 1; i < 32; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          // NOTE: sequential state uses non-blocking assignments only. This
          // lets every register sample pre-edge values, whatever the order.
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        else if (dec_vec[i] && !inc_vec[i])
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_cnt   <= '0;
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({counted_issue, counted_wb})
        2'b10:   pending_cnt <= pending_cnt + 7'd1;
        2'b01:   pending_cnt <= pending_cnt - 7'd1;
        default: pending_cnt <= pending_cnt;
      endcase
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (wb_underflow)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_scoreboard
//
// Directed testbench for id_hazard_scoreboard. Inputs change 1 ns after the
// rising edge. Outputs are sampled 2 ns later, well before the next edge.
// Expected values are hand-derived. The WB-cycle behaviour depends on
// WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_writes, id_kill;
  logic [4:0]  id_rs, id_rt, id_dst, wb_reg;
  logic        wb_valid;
  logic        stall, issue, hazard_rs, hazard_rt, err_underflow;
  logic [6:0]  pending_cnt;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stalls;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  id_hazard_scoreboard #(.MAX_INFLIGHT(3), .PERF_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_writes    (id_writes),
    .id_dst       (id_dst),
    .id_kill      (id_kill),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .stall        (stall),
    .issue        (issue),
    .hazard_rs    (hazard_rs),
    .hazard_rt    (hazard_rt),
    .pending_cnt  (pending_cnt),
    .stall_cycles (stall_cycles),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_writes = 0; id_kill = 0;
    id_rs = 0; id_rt = 0; id_dst = 0; wb_valid = 0; wb_reg = 0;
  endtask

  task automatic id_write(input logic [4:0] dst);
    idle();
    id_valid = 1; id_writes = 1; id_dst = dst;
  endtask

  task automatic id_read_rs(input logic [4:0] rs);
    idle();
    id_valid = 1; id_uses_rs = 1; id_rs = rs;
  endtask

  initial begin
    idle();
    reset = 0;
    #2;
    // Reset state.
    check("rst_stall",   stall, 0);
    check("rst_pending", pending_cnt, 0);
    check("rst_perf",    stall_cycles, 0);
    check("rst_err",     err_underflow, 0);
    tick();
    reset = 1;
    tick();

    // 1: issue a write to $8 with no sources.
    id_write(8); #2;
    check("t1_issue", issue, 1);
    check("t1_stall", stall, 0);
    tick(); idle(); #2;
    check("t1_pending", pending_cnt, 1);

    // 2: RAW on $8 until its WB.
    id_read_rs(8); #2;
    check("t2_stall0",  stall, 1);
    check("t2_haz0",    hazard_rs, 1);
    check("t2_issue0",  issue, 0);
    tick(); #2;
    check("t2_stall1",  stall, 1);
    tick();
    wb_valid = 1; wb_reg = 8; #2;
    check("t2_wb_stall", stall, !BYPASS);
    check("t2_wb_issue", issue, BYPASS);
    tick();
    wb_valid = 0; wb_reg = 0;
    if (!BYPASS) begin
      #2;
      check("t2_late_issue", issue, 1);
      check("t2_late_haz",   hazard_rs, 0);
      tick();
    end
    idle(); #2;
    exp_stalls = BYPASS ? 2 : 3;
    check("t2_perf",    stall_cycles, exp_stalls);
    check("t2_pending", pending_cnt, 0);

    // 3: fill $9 to MAX_INFLIGHT, then a fourth writer stalls on full_dst.
    for (int i = 0; i < 3; i++) begin
      id_write(9); tick();
    end
    idle(); #2;
    check("t3_pending3", pending_cnt, 3);
    id_write(9); #2;
    check("t3_full_stall", stall, 1);
    check("t3_full_issue", issue, 0);
    check("t3_full_haz",   hazard_rs, 0);
    tick();
    wb_valid = 1; wb_reg = 9; #2;
    check("t3_wb_stall", stall, 1);
    tick();
    wb_valid = 0; wb_reg = 0; #2;
    check("t3_after_issue", issue, 1);
    tick(); idle(); #2;
    check("t3_pending", pending_cnt, 3);
    exp_stalls += 2;
    check("t3_perf", stall_cycles, exp_stalls);
    // Drain $9 completely.
    wb_valid = 1; wb_reg = 9;
    tick(); tick(); tick();
    idle(); #2;
    check("t3_drained", pending_cnt, 0);
    check("t3_err",     err_underflow, 0);

    // 4: issue to $10 and WB of $10 on the same edge with cnt[10]=1.
    id_write(10); tick();
    id_write(10); wb_valid = 1; wb_reg = 10; #2;
    check("t4_issue", issue, 1);
    tick(); idle(); #2;
    check("t4_pending", pending_cnt, 1);
    id_read_rs(10); #2;
    check("t4_still_pending", hazard_rs, 1);
    idle(); wb_valid = 1; wb_reg = 10;
    tick(); idle(); id_read_rs(10); #2;
    check("t4_cleared",     hazard_rs, 0);
    check("t4_pending0",    pending_cnt, 0);
    check("t4_err",         err_underflow, 0);

    // 5: register 0 is never pending; WB to idle $12 sets the sticky error.
    id_read_rs(0); wb_valid = 1; wb_reg = 0; #2;
    check("t5_r0_haz",   hazard_rs, 0);
    check("t5_r0_issue", issue, 1);
    tick(); idle(); #2;
    check("t5_r0_pending", pending_cnt, 0);
    check("t5_r0_err",     err_underflow, 0);
    wb_valid = 1; wb_reg = 12;
    tick(); idle(); #2;
    check("t5_err_set",  err_underflow, 1);
    check("t5_pending",  pending_cnt, 0);
    tick(); tick(); #2;
    check("t5_err_sticky", err_underflow, 1);
    check("t5_perf", stall_cycles, exp_stalls);

    // 6: asynchronous reset mid-stall, then a killed instruction with a hazard.
    id_write(8); tick();
    id_write(9); tick();
    id_read_rs(8); #2;
    check("t6_pre_pending", pending_cnt, 2);
    check("t6_pre_stall",   stall, 1);
    reset = 0; #1;
    check("t6_rst_stall",   stall, 0);
    check("t6_rst_haz",     hazard_rs, 0);
    check("t6_rst_pending", pending_cnt, 0);
    check("t6_rst_perf",    stall_cycles, 0);
    check("t6_rst_err",     err_underflow, 0);
    tick();
    reset = 1;
    id_write(8); tick();
    id_read_rs(8); id_kill = 1; #2;
    check("t6_kill_haz",   hazard_rs, 1);
    check("t6_kill_stall", stall, 0);
    check("t6_kill_issue", issue, 0);
    tick(); idle(); #2;
    check("t6_kill_perf",    stall_cycles, 0);
    check("t6_kill_pending", pending_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
